// File: rtl/proc_io_pkg.sv
// Shared types and constants for the processor I/O helpers (data-RAM dump reader).
// Optional checksum support in ram_dump_reader is enabled with RAM_DUMP_CHECKSUM_EN.
package proc_io_pkg;

  localparam int RAM_DEPTH = 102;
  localparam int RAM_IDX_W = 12;
  localparam int WORD_W    = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } dump_state_t;

  // Word index to byte address on the data-RAM bus (bits [13:2] carry the index).
  function automatic logic [31:0] word_to_byte_addr(input logic [RAM_IDX_W-1:0] idx);
    return {{(30-RAM_IDX_W){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/dump_idx_counter.sv
// Modulo-DEPTH word index plus remaining-word counter for the RAM dump reader.
module dump_idx_counter
  import proc_io_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int IDX_W = RAM_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_load_idx,
  input  logic [IDX_W-1:0] i_load_cnt,
  input  logic             i_step,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LP_DEPTH = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] LP_MAX   = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cnt;

  // Load folds an out-of-range start index into the RAM; step wraps at DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_idx <= i_load_idx % LP_DEPTH;
      r_cnt <= i_load_cnt;
    end else if (i_step) begin
      r_idx <= (r_idx == LP_MAX) ? '0 : r_idx + IDX_W'(1);
      r_cnt <= r_cnt - IDX_W'(1);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_cnt == IDX_W'(1));

endmodule

// File: rtl/ram_dump_reader.sv
// Bus initiator streaming a window of the data RAM to a valid/ready sink.
// Define RAM_DUMP_CHECKSUM_EN to add a modulo-2^32 checksum of the streamed words.
module ram_dump_reader
  import proc_io_pkg::*;
#(
  parameter int DEPTH  = RAM_DEPTH,
  parameter int IDX_W  = RAM_IDX_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_idx,
  input  logic [IDX_W-1:0]  num_words,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [31:0]       mem_a,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef RAM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum,
  output logic              checksum_valid
`endif
);

  dump_state_t       r_state;
  dump_state_t       w_next;
  logic              w_load;
  logic              w_step;
  logic              w_capture;
  logic              w_last;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;

  dump_idx_counter #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_idx_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_idx (start_idx),
    .i_load_cnt (num_words),
    .i_step     (w_step),
    .o_idx      (w_idx),
    .o_last     (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the load/step/capture strobes for the datapath.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = (num_words == '0) ? DONE : REQ;
        end else begin
          w_next = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          w_next = FETCH;
        end else begin
          w_next = REQ;
        end
      end
      FETCH: begin
        if (bus_gnt) begin
          w_capture = 1'b1;
          w_next    = SEND;
        end else begin
          w_next = REQ;
        end
      end
      SEND: begin
        if (out_ready) begin
          w_step = 1'b1;
          if (w_last) begin
            w_next = DONE;
          end else if (bus_gnt) begin
            w_next = FETCH;
          end else begin
            w_next = REQ;
          end
        end else begin
          w_next = SEND;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output word register: loaded from the RAM in FETCH, released on the sink handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_capture) begin
      r_out_data  <= mem_rd;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
    end else if (w_step) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign bus_req   = (r_state == REQ) || (r_state == FETCH) || (r_state == SEND);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign mem_a     = (r_state == FETCH) ? word_to_byte_addr(RAM_IDX_W'(w_idx)) : 32'h0000_0000;

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running sum of handshaken words; held after DONE until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_load) begin
      r_checksum <= '0;
    end else if (w_step) begin
      r_checksum <= r_checksum + r_out_data;
    end
  end

  assign checksum       = r_checksum;
  assign checksum_valid = (r_state == DONE);
`endif

endmodule

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader: directed scenarios plus randomized dumps
// checked against a word-list model of the RAM window (RAM_DUMP_CHECKSUM_EN optional).
module tb_ram_dump_reader;

  localparam int DEPTH = 102;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_idx = 12'd0;
  logic [11:0] num_words = 12'd0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] mem_a;
  logic [31:0] mem_rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
  logic        checksum_valid;
`endif

  logic [31:0] ram [0:DEPTH-1];
  int n_checks = 0;
  int n_fail   = 0;

  ram_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_idx (start_idx),
    .num_words (num_words),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .mem_a     (mem_a),
    .mem_rd    (mem_rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef RAM_DUMP_CHECKSUM_EN
    ,
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  always #5 clk = ~clk;

  // Asynchronous RAM read port.
  always_comb begin
    int ai;
    ai = int'(mem_a[31:2]);
    if (ai < DEPTH) mem_rd = ram[ai];
    else mem_rd = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_idx(input int sidx, input int k);
    return ((sidx % DEPTH) + k) % DEPTH;
  endfunction

  function automatic logic pick(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic run_dump(input int sidx, input int n, input int gnt_pct, input int rdy_pct,
                          input int stall_word, input int stall_len,
                          input int drop_word, input int drop_len, output int first_valid);
    int k, cyc, rises, stall_left, drop_left, drop_obs, limit;
    bit got_done, stalled, dropped, prev_valid, prev_ready;
    logic [31:0] sum, prev_data, exp_word;
    k = 0; cyc = 0; rises = 0; stall_left = 0; drop_left = 0; drop_obs = 0;
    got_done = 1'b0; stalled = 1'b0; dropped = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    sum = 32'd0; prev_data = 32'd0; first_valid = -1;
    limit = 60 * n + 50;
    start = 1'b1; start_idx = 12'(sidx); num_words = 12'(n);
    bus_gnt = pick(gnt_pct); out_ready = pick(rdy_pct);
    @(negedge clk);
    start = 1'b0;
    while (!got_done && cyc < limit) begin
      exp_word = (k < n) ? ram[exp_idx(sidx, k)] : 32'd0;
      check("busy", busy, 1'b1);
`ifdef RAM_DUMP_CHECKSUM_EN
      check("cks_valid", checksum_valid, done);
`endif
      if (done) begin
        got_done = 1'b1;
        check("done_words", k, n);
        check("done_req", bus_req, 1'b0);
        check("done_valid", out_valid, 1'b0);
`ifdef RAM_DUMP_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
      end else begin
        check("req_held", bus_req, 1'b1);
        if (mem_a != 32'd0) begin
          check("mem_a", mem_a, 32'(exp_idx(sidx, k) * 4));
          check("valid_in_fetch", out_valid, 1'b0);
        end
        if (drop_obs > 0) begin
          check("mem_a_in_req", mem_a, 32'd0);
          drop_obs--;
        end
        if (prev_valid && !prev_ready) begin
          check("stable_valid", out_valid, 1'b1);
          check("stable_data", out_data, prev_data);
        end
        if (out_valid) begin
          if (!prev_valid) begin
            rises++;
            if (first_valid < 0) first_valid = cyc;
          end
          check("data", out_data, exp_word);
          check("last", out_last, (k == n - 1));
        end
      end
      // Inputs for the coming edge: directed grant drop / backpressure, else random.
      if (drop_left > 0) begin
        bus_gnt = 1'b0; drop_left--;
      end else if (!dropped && k == drop_word && mem_a != 32'd0 && !out_valid) begin
        bus_gnt = 1'b0; dropped = 1'b1; drop_left = drop_len - 1; drop_obs = drop_len;
      end else begin
        bus_gnt = pick(gnt_pct);
      end
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else if (!stalled && k == stall_word && out_valid) begin
        out_ready = 1'b0; stalled = 1'b1; stall_left = stall_len - 1;
      end else begin
        out_ready = pick(rdy_pct);
      end
      start = (cyc == 2);
      if (start) begin
        start_idx = 12'($urandom); num_words = 12'($urandom);
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
      if (out_valid && out_ready) begin
        sum = sum + exp_word;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("no_timeout", got_done, 1'b1);
    check("valid_rises", rises, n);
    @(negedge clk);
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_mem_a", mem_a, 32'd0);
  endtask

  initial begin
    int fv;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    ram[5] = 32'hA; ram[6] = 32'hB; ram[7] = 32'hC;

    repeat (2) @(negedge clk);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_a", mem_a, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_dump(5, 3, 100, 100, -1, 0, -1, 0, fv);
    check("first_valid_latency", fv, 2);
    run_dump(100, 4, 100, 100, -1, 0, -1, 0, fv);
    run_dump(10, 3, 100, 100, 1, 5, -1, 0, fv);
    run_dump(20, 3, 100, 100, -1, 0, 1, 3, fv);
    run_dump(40, 0, 100, 100, -1, 0, -1, 0, fv);
    check("zero_words_no_valid", fv, 32'hFFFF_FFFF);

    // Reset while a word waits in SEND.
    start = 1'b1; start_idx = 12'd30; num_words = 12'd5; bus_gnt = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_bus_req", bus_req, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_last", out_last, 1'b0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_mem_a", mem_a, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("arst_no_done", done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    run_dump(101, 5, 100, 100, -1, 0, -1, 0, fv);

    for (int t = 0; t < 6; t++) begin
      run_dump(int'($urandom_range(4095)), int'($urandom_range(200, 1)), 70, 60, -1, 0, -1, 0, fv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
